// File: rtl/booth_product_unloader.sv
// booth_product_unloader: captures a 2*Width product and unloads it as two Width-bit beats over valid/ready.
// Optional macro BOOTH_UNLOAD_MSB_FIRST_EN sends the upper half first.
module booth_product_unloader #(
   parameter int Width = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [2*Width-1:0] prod_in,
   input  logic               prod_done,
   output logic [Width-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_last,
   output logic               busy,
   output logic               overflow,
   input  logic               ovf_clr
);
   typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;
   state_t             state, state_n;
   logic [2*Width-1:0] active, active_n, pending, pending_n;
   logic               pending_vld, pending_vld_n, drop, xfer;
   logic [Width-1:0]   first_n, second_n, data_n;
   assign xfer = out_valid && out_ready;
   always_comb begin
      state_n       = state;
      active_n      = active;
      pending_n     = pending;
      pending_vld_n = pending_vld;
      drop          = 1'b0;
      case (state)
         IDLE: if (prod_done) begin
            active_n = prod_in;
            state_n  = SEND_LO;
         end
         SEND_LO: begin
            state_n = xfer ? SEND_HI : SEND_LO;
            if (prod_done && !pending_vld) begin
               pending_n     = prod_in;
               pending_vld_n = 1'b1;
            end else if (prod_done)
               drop = 1'b1;
         end
         SEND_HI: if (xfer) begin
            // the freed active slot lets a coincident strobe in without a drop
            if (pending_vld) begin
               active_n      = pending;
               state_n       = SEND_LO;
               pending_n     = prod_done ? prod_in : pending;
               pending_vld_n = prod_done;
            end else if (prod_done) begin
               active_n = prod_in;
               state_n  = SEND_LO;
            end else
               state_n = IDLE;
         end else if (prod_done && !pending_vld) begin
            pending_n     = prod_in;
            pending_vld_n = 1'b1;
         end else if (prod_done)
            drop = 1'b1;
         default: state_n = IDLE;
      endcase
   end
`ifdef BOOTH_UNLOAD_MSB_FIRST_EN
   assign first_n  = active_n[2*Width-1:Width];
   assign second_n = active_n[Width-1:0];
`else
   assign first_n  = active_n[Width-1:0];
   assign second_n = active_n[2*Width-1:Width];
`endif
   assign data_n = state_n == SEND_LO ? first_n : state_n == SEND_HI ? second_n : '0;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         active      <= '0;
         pending     <= '0;
         pending_vld <= 1'b0;
         out_data    <= '0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         busy        <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         state       <= state_n;
         active      <= active_n;
         pending     <= pending_n;
         pending_vld <= pending_vld_n;
         out_data    <= data_n;
         out_valid   <= state_n != IDLE;
         out_last    <= state_n == SEND_HI;
         busy        <= state_n != IDLE || pending_vld_n;
         overflow    <= drop ? 1'b1 : ovf_clr ? 1'b0 : overflow;
      end
   end
endmodule

// File: tb/tb_booth_product_unloader.sv
// tb_booth_product_unloader: directed plus random stimulus checked against a queue-based product model.
module tb_booth_product_unloader;
   logic        clk, reset, prod_done, out_valid, out_ready, out_last, busy, overflow, ovf_clr;
   logic [31:0] prod_in;
   logic [15:0] out_data;
   int          vectors, miscompares;
   logic [31:0] q[$];
   int          beat;
   logic        movf;

   booth_product_unloader #(.Width(16)) dut (
      .clk(clk), .reset(reset), .prod_in(prod_in), .prod_done(prod_done),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .overflow(overflow), .ovf_clr(ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] exp_data();
      logic [31:0] p;
      if (q.size() == 0) return 16'h0;
      p = q[0];
`ifdef BOOTH_UNLOAD_MSB_FIRST_EN
      return beat == 0 ? p[31:16] : p[15:0];
`else
      return beat == 0 ? p[15:0] : p[31:16];
`endif
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".valid"}, 32'(out_valid), 32'(q.size() > 0));
      chk({tag, ".data"}, 32'(out_data), 32'(exp_data()));
      chk({tag, ".last"}, 32'(out_last), 32'(q.size() > 0 && beat == 1));
      chk({tag, ".busy"}, 32'(busy), 32'(q.size() > 0));
      chk({tag, ".ovf"}, 32'(overflow), 32'(movf));
   endtask

   // Products in flight form a queue of at most two; a strobe joins if fewer than two remain after this cycle's unload.
   task automatic step(input string tag, input logic pd, input logic [31:0] pin, input logic rdy, input logic clr);
      logic drop;
      prod_done = pd; prod_in = pin; out_ready = rdy; ovf_clr = clr;
      @(posedge clk);
      drop = 1'b0;
      if (q.size() > 0 && rdy) begin
         if (beat == 0) beat = 1;
         else begin
            void'(q.pop_front());
            beat = 0;
         end
      end
      if (pd) begin
         if (q.size() < 2) q.push_back(pin);
         else drop = 1'b1;
      end
      movf = drop ? 1'b1 : clr ? 1'b0 : movf;
      #1;
      check_all(tag);
   endtask

   task automatic async_reset(input string tag);
      #2 reset = 1'b1;
      #1;
      chk({tag, ".valid"}, 32'(out_valid), 32'd0);
      chk({tag, ".last"}, 32'(out_last), 32'd0);
      chk({tag, ".data"}, 32'(out_data), 32'd0);
      chk({tag, ".busy"}, 32'(busy), 32'd0);
      chk({tag, ".ovf"}, 32'(overflow), 32'd0);
      q.delete(); beat = 0; movf = 1'b0;
      #1 reset = 1'b0;
   endtask

   initial begin
      vectors = 0; miscompares = 0; q.delete(); beat = 0; movf = 1'b0;
      reset = 1'b1; prod_done = 1'b0; prod_in = '0; out_ready = 1'b0; ovf_clr = 1'b0;
      #3 check_all("reset");
      #9 reset = 1'b0;
      // 1: basic unload
      step("t1.cap", 1, 32'hDEAD_BEEF, 1, 0);
      chk("t1.lo", 32'(out_data), 32'h0000_BEEF ^ 32'(0));
      step("t1.lo", 0, 0, 1, 0);
      step("t1.hi", 0, 0, 1, 0);
      step("t1.idle", 0, 0, 1, 0);
      // 2: backpressure on the high beat
      step("t2.cap", 1, 32'h1234_5678, 1, 0);
      step("t2.lo", 0, 0, 1, 0);
      for (int i = 0; i < 5; i++) step("t2.hold", 0, 0, 0, 0);
      step("t2.go", 0, 0, 1, 0);
      step("t2.idle", 0, 0, 1, 0);
      // 3: pending and back-to-back
      step("t3.a", 1, 32'h0000_0001, 0, 0);
      step("t3.b", 1, 32'h0000_0002, 0, 0);
      for (int i = 0; i < 5; i++) step("t3.drain", 0, 0, 1, 0);
      // 4: overflow, clear, and clear losing to a drop
      step("t4.a", 1, 32'hAAAA_0A0A, 0, 0);
      step("t4.b", 1, 32'hBBBB_0B0B, 0, 0);
      step("t4.c", 1, 32'hCCCC_0C0C, 0, 0);
      step("t4.clr", 0, 0, 0, 1);
      step("t4.d", 1, 32'hDDDD_0D0D, 0, 1);
      for (int i = 0; i < 5; i++) step("t4.drain", 0, 0, 1, 0);
      step("t4.clr2", 0, 0, 1, 1);
      // 5: strobe coincides with the high-beat transfer while pending is full
      step("t5.a", 1, 32'h1111_AAAA, 0, 0);
      step("t5.b", 1, 32'h2222_BBBB, 1, 0);
      step("t5.c", 1, 32'h3333_CCCC, 1, 0);
      for (int i = 0; i < 7; i++) step("t5.drain", 0, 0, 1, 0);
      // 6: async reset during the high beat, then a normal unload
      step("t6.cap", 1, 32'hFACE_CAFE, 1, 0);
      step("t6.lo", 1, 32'h5555_6666, 1, 0);
      async_reset("t6.rst");
      step("t6.cap2", 1, 32'h0BAD_F00D, 1, 0);
      for (int i = 0; i < 3; i++) step("t6.drain", 0, 0, 1, 0);
      // random traffic
      for (int i = 0; i < 2000; i++)
         step("rand", 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
